// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive path:
//     - rx_state_e     : receiver FSM state encoding
//     - calc_div       : system clocks per oversample tick
//     - calc_cnt_width : counter width needed to count 0..div-1
//   Both functions are constant functions, so they can size localparams.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Clocks between sample ticks. Clamped to 1 so a degenerate parameter set
  // still yields a tick every clock instead of a zero-length divider.
  function automatic int calc_div(input int clk_freq,
                                  input int baud_rate,
                                  input int oversample);
    int div;
    div = clk_freq / (baud_rate * oversample);
    if (div < 1) div = 1;
    return div;
  endfunction

  // $clog2(div), but never narrower than one bit.
  function automatic int calc_cnt_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Free-running divider producing a one-clock sample tick every
//   DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE) system clocks.
//
// Ports
//   clk       in   system clock
//   restart_i in   synchronous clear of the divider (no tick while high)
//   tick_o    out  one-cycle sample strobe
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic restart_i,
  output logic tick_o
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = calc_cnt_width(DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  assign wrap   = (cnt_q == LAST_CNT);
  assign tick_o = wrap && !restart_i;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule : uart_baud_tick

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   Oversampling UART receiver: start-bit glitch rejection, mid-bit sampling,
//   LSB-first data, optional even parity, stop-bit check, one-word output
//   buffer with valid/ready handshake and sticky error flags.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : one even-parity bit follows the data bits and is checked
//     undefined : frame is start + DATA_BITS + stop, parity_err tied low
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   rxd          in   asynchronous serial line, idle high
//   rx_data      out  received word (first line bit is the LSB)
//   rx_valid     out  rx_data holds an unread word
//   rx_ready     in   consumer takes the word when rx_valid && rx_ready
//   frame_err    out  sticky: stop bit sampled low
//   overrun_err  out  sticky: word completed while the buffer was full
//   parity_err   out  sticky: parity mismatch
//   err_clr      in   one-cycle pulse clearing all sticky flags
// -----------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  input  logic                 err_clr
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] MID_SAMPLE  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Line synchroniser and sample tick
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rxd_s;
  logic       tick;

  assign rxd_s = sync_q[1];

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk       (clk),
    .restart_i (reset),
    .tick_o    (tick)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver;
  logic                 frame_set;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 par_set;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    par_set   = 1'b0;
`endif

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_d = ST_START;
            samp_d  = '0;
          end
        end

        // Re-check the line half a bit in; a short low pulse is noise.
        ST_START: begin
          if (samp_q == MID_SAMPLE) begin
            if (rxd_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              samp_d  = '0;
              bit_d   = '0;
            end
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end

        // Counter was restarted at mid start bit, so LAST_SAMPLE lands on
        // the middle of each following bit.
        ST_DATA: begin
          if (samp_q == LAST_SAMPLE) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            samp_d  = '0;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (samp_q == LAST_SAMPLE) begin
            par_bit_d = rxd_s;
            samp_d    = '0;
            state_d   = ST_STOP;
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
`endif

        // Leave for IDLE at mid stop bit so a start bit that follows
        // immediately is still caught on its leading edge.
        ST_STOP: begin
          if (samp_q == LAST_SAMPLE) begin
            state_d   = ST_IDLE;
            samp_d    = '0;
            frame_set = !rxd_s;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit carry an even count of ones.
            par_set = (^shift_q) != par_bit_q;
            deliver = rxd_s && !par_set;
`else
            deliver = rxd_s;
`endif
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          samp_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer and sticky flags
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_q, frame_d;
  logic                 over_q, over_d;
  logic                 over_set;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    over_set   = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // A word arriving in the same cycle as a handshake replaces the old one
    // cleanly; only an unread, un-acknowledged buffer counts as an overrun.
    if (deliver) begin
      if (rx_valid_q && !rx_ready) begin
        over_set = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end

    // A flag being set in the clearing cycle stays set.
    frame_d = frame_set || (frame_q && !err_clr);
    over_d  = over_set  || (over_q  && !err_clr);
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_err_d  = par_set || (par_err_q && !err_clr);
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // values present before the clock edge, regardless of statement order.
    if (reset) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      samp_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      frame_q    <= 1'b0;
      over_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], rxd};
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frame_q    <= frame_d;
      over_q     <= over_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_q;
  assign overrun_err = over_q;

endmodule : uart_rx_core

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Drives whole UART frames onto rxd and compares the receiver's outputs with
//   a frame-level model: each frame either delivers a word, overruns, or raises
//   error flags, and every handshake is counted. The clock is scaled so one
//   sample tick is four system clocks (nominal 9600 baud, 16x oversampling).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CLK_FREQ   = 614_400;
  localparam int BAUD_RATE  = 9_600;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int DIV        = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int BIT_CLKS   = DIV * OVERSAMPLE;

  logic                 clk      = 1'b0;
  logic                 reset    = 1'b1;
  logic                 rxd      = 1'b1;
  logic                 rx_ready = 1'b0;
  logic                 err_clr  = 1'b0;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 parity_err;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .err_clr     (err_clr)
  );

  int n_checks = 0;
  int n_errors = 0;
  int hs_seen  = 0;

  // Reference model state
  logic                 m_valid;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_frame;
  logic                 m_over;
  logic                 m_par;
  int                   m_hs;

  // Inputs change 2 ns after a rising edge; outputs are sampled on the
  // falling edge, where a valid&&ready pair means a transfer at the next edge.
  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) hs_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_frame = 1'b0;
    m_over  = 1'b0;
    m_par   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    check({tag, ".valid"},   32'(rx_valid),    32'(m_valid));
    check({tag, ".data"},    32'(rx_data),     32'(m_data));
    check({tag, ".frame"},   32'(frame_err),   32'(m_frame));
    check({tag, ".overrun"}, 32'(overrun_err), 32'(m_over));
    check({tag, ".parity"},  32'(parity_err),  32'(m_par));
    check({tag, ".xfers"},   32'(hs_seen),     32'(m_hs));
  endtask

  task automatic set_ready(input logic r);
    drive_edge();
    rx_ready = r;
    if (r && m_valid) begin
      m_hs++;
      m_valid = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_err_clr();
    drive_edge();
    err_clr = 1'b1;
    drive_edge();
    err_clr = 1'b0;
    m_frame = 1'b0;
    m_over  = 1'b0;
    m_par   = 1'b0;
  endtask

  task automatic pulse_reset();
    drive_edge();
    reset = 1'b1;
    repeat (2) drive_edge();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send_bit(input logic b);
    drive_edge();
    rxd = b;
    repeat (BIT_CLKS - 1) @(posedge clk);
  endtask

  // Frame outcome by the protocol rules: a bad stop bit or bad parity flags an
  // error and drops the word; a good word lands in the buffer unless it is
  // full and not being read; a ready consumer takes it.
  task automatic model_frame(input logic [DATA_BITS-1:0] d, input logic stop_b,
                             input logic par_ok);
    if (!stop_b) m_frame = 1'b1;
    if (!par_ok) m_par = 1'b1;
    if (stop_b && par_ok) begin
      if (m_valid && !rx_ready) begin
        m_over = 1'b1;
      end else begin
        m_data  = d;
        m_valid = 1'b1;
      end
    end
    if (rx_ready && m_valid) begin
      m_hs++;
      m_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_b,
                            input logic bad_par, input int idle_bits);
    logic par_ok;
    par_ok = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ bad_par);
    par_ok = !bad_par;
`endif
    send_bit(stop_b);
    drive_edge();
    rxd = 1'b1;
    repeat (idle_bits * BIT_CLKS) @(posedge clk);
    model_frame(d, stop_b, par_ok);
  endtask

  initial begin
    logic [DATA_BITS-1:0] d;
    logic                 stop_b;
    logic                 bad_par;
    int                   idle;

    model_reset();
    m_hs = 0;
    repeat (4) @(posedge clk);
    drive_edge();
    reset = 1'b0;
    check_all("reset");

    // Single byte, consumer always ready
    set_ready(1'b1);
    send_frame(8'hA5, 1'b1, 1'b0, 2);
    check_all("byte_a5");

    // Three-sample low pulse on an idle line
    drive_edge();
    rxd = 1'b0;
    repeat (3 * DIV - 1) @(posedge clk);
    drive_edge();
    rxd = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    check_all("glitch");

    // Stop bit low, then clear the flag
    send_frame(8'h3C, 1'b0, 1'b0, 2);
    check_all("stop_low");
    pulse_err_clr();
    check_all("err_clr");

    // Back-to-back words into a full buffer, then drain
    set_ready(1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 2);
    check_all("overrun");
    set_ready(1'b1);
    check_all("drain");
    pulse_err_clr();
    check_all("overrun_clr");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 2);
    check_all("parity_bad");
    pulse_err_clr();
    send_frame(8'h07, 1'b1, 1'b0, 2);
    check_all("parity_good");
`endif

    // Reset in the middle of data bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    drive_edge();
    rxd = 1'b1;
    repeat (BIT_CLKS / 2) @(posedge clk);
    pulse_reset();
    repeat (6 * BIT_CLKS) @(posedge clk);
    check_all("mid_reset");
    send_frame(8'h5A, 1'b1, 1'b0, 2);
    check_all("after_reset");

    // Random traffic
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) set_ready(!rx_ready);
      d       = DATA_BITS'($urandom);
      stop_b  = ($urandom_range(0, 7) != 0);
      bad_par = ($urandom_range(0, 5) == 0);
      // A low stop bit needs idle time before the next start edge is real.
      idle    = stop_b ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, stop_b, bad_par, idle);
      check_all($sformatf("rand%0d", k));
      if (k % 8 == 7) pulse_err_clr();
    end

    set_ready(1'b1);
    check_all("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_uart_rx_core

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9_600, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, samples per bit (even, 4..16).
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..8).
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-007 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port rx_data, output, DATA_BITS, received word, LSB first on line.
REQ-009 SHALL have port rx_valid, output, 1, rx_data holds an unread word.
REQ-010 SHALL have port rx_ready, input, 1, consumer accepts word when rx_valid and rx_ready are both high.
REQ-011 SHALL have port frame_err, output, 1, sticky: stop bit sampled low.
REQ-012 SHALL have port overrun_err, output, 1, sticky: word completed while rx_valid high.
REQ-013 SHALL have port parity_err, output, 1, sticky: parity mismatch (constant 0 when parity compiled out).
REQ-014 SHALL have port err_clr, input, 1, one-cycle pulse clears all sticky error flags.

Function
REQ-015 SHALL pass rxd through a 2-flop synchroniser reset to 1; all logic uses the synchronised signal.
REQ-016 SHALL generate a one-cycle sample tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks; counter width $clog2(DIV).
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE -> START on first tick with synchronised rxd low; sample counter cleared.
REQ-019 START: at sample OVERSAMPLE/2-1, rxd high -> IDLE (glitch reject, no error); else sample counter restarted, -> DATA.
REQ-020 DATA: sample each bit at counter OVERSAMPLE-1 (mid-bit), shift right into DATA_BITS register; after DATA_BITS bits -> PARITY if compiled in, else STOP.
REQ-021 STOP: sample at mid-bit; low sets frame_err and discards word; high delivers word; either way -> IDLE at that same tick (next start detectable immediately).
REQ-022 Delivery: rx_data loaded and rx_valid set the cycle after the stop-bit sample.
REQ-023 rx_valid SHALL clear on handshake; rx_data holds stable while rx_valid high.
REQ-024 Delivery while rx_valid high and no simultaneous handshake SHALL set overrun_err and keep the old word; delivery coinciding with handshake SHALL load the new word, rx_valid stays 1, no overrun.
REQ-025 Error set and err_clr in same cycle: set wins.
REQ-026 Receiver SHALL continue receiving while rx_valid high (no line backpressure).

Reset
REQ-027 reset SHALL force IDLE, all counters 0, shift register 0, rx_data 0, rx_valid 0, all error flags 0, synchroniser 1.
REQ-028 reset mid-frame SHALL abandon the frame with no delivery or error; next falling edge after release starts a fresh frame.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: PARITY state samples one bit after data; even parity checked; mismatch sets parity_err and discards word; stop bit still checked.
REQ-030 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is start+DATA_BITS+stop, parity_err tied 0.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state enum type and a constant function computing DIV and counter width.
REQ-032 Baud/sample tick generator SHALL be sub-module uart_baud_tick (parameters CLK_FREQ, BAUD_RATE, OVERSAMPLE; output tick; restart input).

Verification
REQ-033 Byte 0xA5, 9600 baud, rx_ready held 1 -> rx_data=0xA5, rx_valid one-cycle pulse, no errors.
REQ-034 Start pulse low for 3 samples only -> returns IDLE, no rx_valid, no errors.
REQ-035 0x3C with stop bit driven low -> frame_err=1, rx_valid stays 0; err_clr pulse -> frame_err=0.
REQ-036 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11, overrun_err=1; raise rx_ready -> rx_valid drops.
REQ-037 UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err=1, no delivery; parity bit 1 -> rx_data=0x07.
REQ-038 reset asserted during data bit 4 of 0xFF, then 0x5A sent -> only 0x5A delivered, no errors.
